time_counter: RTL and testbench
===============================

# time_counter

Timekeeping core of the digital clock. Divides the system clock down to a 1 Hz enable and advances a 24-hour BCD time-of-day (HH:MM:SS). Accepts a validated load of hours/minutes from the time-setting logic. Drives the `*_timing` digit inputs of the display multiplexer, plus per-second, per-hour and per-day strobes for the alarm and chime logic.

## Interface
- `CLK_HZ`, default 1000: system clock cycles per second; prescaler modulus; must be ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `run`  in  1  1 = timekeeping advances; 0 = prescaler and digits hold (setting mode).
- `load`  in  1  single-cycle request to load setting digits.
- `hr_high_setting`, `hr_low_setting`, `min_high_setting`, `min_low_setting`  in  4 each  BCD load values.
- `hr_high_timing`, `hr_low_timing`, `min_high_timing`, `min_low_timing`, `sec_high_timing`, `sec_low_timing`  out  4 each  current time, BCD, registered.
- `sec_tick`  out  1  one-cycle pulse on every seconds advance.
- `hour_pulse`  out  1  one-cycle pulse when MM:SS wraps 59:59→00:00.
- `day_pulse`  out  1  one-cycle pulse when time wraps 23:59:59→00:00:00.
- `load_err`  out  1  one-cycle pulse when a `load` is rejected.

## Operation
- Reset: all digits 0 (00:00:00), prescaler 0, all pulse outputs 0.
- Prescaler: `ceil(log2(CLK_HZ))`-bit counter.
  - With `run`=1, it increments each cycle.
  - At `CLK_HZ-1` it wraps to 0; that cycle is a tick cycle.
  - With `run`=0, it holds its value.
- Tick cycle: time advances by one second with a BCD cascade.
  - `sec_low` 9→0 carries into `sec_high`.
  - `sec_high` 5→0 carries into `min_low`.
  - `min_low` 9→0 carries into `min_high`.
  - `min_high` 5→0 carries into the hours.
  - Hours: `hr_low` 9→0 increments `hr_high`. 23 (`hr_high`=2, `hr_low`=3) wraps to 00.
  - No digit ever holds a value above its legal maximum.
- Load is valid iff:
  - `hr_high` ≤ 2,
  - `hr_low` ≤ 9, and `hr_low` ≤ 3 when `hr_high`=2,
  - `min_high` ≤ 5,
  - `min_low` ≤ 9.
- Valid load:
  - Hours and minutes take the setting digits.
  - Seconds clear to 00.
  - Prescaler clears to 0.
  - No pulses are generated that cycle.
- Invalid load: time and prescaler are unchanged, except that a normal tick still proceeds. `load_err` pulses.
- Priority: `rst` > valid `load` > tick.
  - A valid load in a tick cycle suppresses that tick: no `sec_tick`, and the loaded time is exact.
  - `load` is honoured regardless of `run`.
- Pulses:
  - `sec_tick` accompanies every advance.
  - `hour_pulse` accompanies an advance whose result has MM:SS = 00:00.
  - `day_pulse` accompanies an advance whose result is 00:00:00. `hour_pulse` is also high in that cycle.

## Timing
- All outputs are registered. Digit outputs and pulses change on the rising edge ending the tick cycle, and are visible in the following cycle.
- Pulses are exactly one cycle wide. Consecutive `sec_tick` pulses are exactly `CLK_HZ` cycles apart while `run`=1 and there is no load.
- Latency from `load` sampled high to new digits or `load_err` visible: 1 cycle.
- From a valid load, the first `sec_tick` comes `CLK_HZ` cycles after the load edge, provided `run`=1 throughout.
- `run` deasserted mid-second, then reasserted: counting resumes from the held prescaler value. The partial second is preserved, not restarted.
- `rst` asserted mid-second or during `load`: the next state is the reset state and the load is discarded.

## Test plan
- Reset, `CLK_HZ`=4: hold `rst` for 2 cycles, then release with `run`=1.
  - Required: all digits 0, no pulses while in reset.
  - Required: first `sec_tick` 4 cycles after release, time then 00:00:01.
- Rollover: load 23:59 and run 59 s.
  - Required: time reads 23:59:59.
  - Required: next tick gives 00:00:00 with `sec_tick`, `hour_pulse` and `day_pulse` all high for exactly one cycle.
- Hour boundary: load 09:59, then 60 ticks.
  - Required: 10:00:00, `hour_pulse` high and `day_pulse` low.
- Invalid load: load `hr_high`=2, `hr_low`=4 while showing 12:34:56, and separately load `min_high`=6.
  - Required in each case: `load_err` pulses one cycle and time is unchanged.
- Hold: deassert `run` for 10 cycles at prescaler value 2, then reassert.
  - Required: digits frozen while `run`=0.
  - Required: next `sec_tick` 2 cycles after reassertion.
- Collision: assert valid `load` of 07:30 exactly in a tick cycle.
  - Required: 07:30:00, no `sec_tick`, next tick `CLK_HZ` cycles later giving 07:30:01.

Source files
------------

// File: rtl/time_counter.sv
// Timekeeping core: divides clk to a 1 Hz tick and advances a 24-hour BCD HH:MM:SS,
// with validated hour/minute loading and per-second/hour/day strobes.
module time_counter #(
    parameter int CLK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic [3:0] hr_high_setting,
    input  logic [3:0] hr_low_setting,
    input  logic [3:0] min_high_setting,
    input  logic [3:0] min_low_setting,
    output logic [3:0] hr_high_timing,
    output logic [3:0] hr_low_timing,
    output logic [3:0] min_high_timing,
    output logic [3:0] min_low_timing,
    output logic [3:0] sec_high_timing,
    output logic [3:0] sec_low_timing,
    output logic       sec_tick,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          load_ok;
    logic          wrap_hour;
    logic          wrap_day;
    logic [3:0]    n_hh, n_hl, n_mh, n_ml, n_sh, n_sl;

    assign tick = run && (presc == PRESC_MAX);

    assign load_ok = (hr_high_setting <= 4'd2)
                  && (hr_low_setting  <= 4'd9)
                  && !(hr_high_setting == 4'd2 && hr_low_setting > 4'd3)
                  && (min_high_setting <= 4'd5)
                  && (min_low_setting  <= 4'd9);

    // MM:SS at 59:59 means the next advance lands on a full hour; 23:59:59 on a new day.
    assign wrap_hour = (sec_low_timing == 4'd9) && (sec_high_timing == 4'd5)
                    && (min_low_timing == 4'd9) && (min_high_timing == 4'd5);
    assign wrap_day  = wrap_hour && (hr_high_timing == 4'd2) && (hr_low_timing == 4'd3);

    always_comb begin
        n_hh = hr_high_timing;
        n_hl = hr_low_timing;
        n_mh = min_high_timing;
        n_ml = min_low_timing;
        n_sh = sec_high_timing;
        n_sl = sec_low_timing;
        if (sec_low_timing != 4'd9) begin
            n_sl = sec_low_timing + 4'd1;
        end else begin
            n_sl = 4'd0;
            if (sec_high_timing != 4'd5) begin
                n_sh = sec_high_timing + 4'd1;
            end else begin
                n_sh = 4'd0;
                if (min_low_timing != 4'd9) begin
                    n_ml = min_low_timing + 4'd1;
                end else begin
                    n_ml = 4'd0;
                    if (min_high_timing != 4'd5) begin
                        n_mh = min_high_timing + 4'd1;
                    end else begin
                        n_mh = 4'd0;
                        if (hr_high_timing == 4'd2 && hr_low_timing == 4'd3) begin
                            n_hh = 4'd0;
                            n_hl = 4'd0;
                        end else if (hr_low_timing == 4'd9) begin
                            n_hl = 4'd0;
                            n_hh = hr_high_timing + 4'd1;
                        end else begin
                            n_hl = hr_low_timing + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc           <= '0;
            hr_high_timing  <= 4'd0;
            hr_low_timing   <= 4'd0;
            min_high_timing <= 4'd0;
            min_low_timing  <= 4'd0;
            sec_high_timing <= 4'd0;
            sec_low_timing  <= 4'd0;
            sec_tick        <= 1'b0;
            hour_pulse      <= 1'b0;
            day_pulse       <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            sec_tick   <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            load_err   <= 1'b0;
            if (load && load_ok) begin
                // A valid load wins over a coincident tick so the loaded time is exact.
                presc           <= '0;
                hr_high_timing  <= hr_high_setting;
                hr_low_timing   <= hr_low_setting;
                min_high_timing <= min_high_setting;
                min_low_timing  <= min_low_setting;
                sec_high_timing <= 4'd0;
                sec_low_timing  <= 4'd0;
            end else begin
                load_err <= load;
                if (run)
                    presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    hr_high_timing  <= n_hh;
                    hr_low_timing   <= n_hl;
                    min_high_timing <= n_mh;
                    min_low_timing  <= n_ml;
                    sec_high_timing <= n_sh;
                    sec_low_timing  <= n_sl;
                    sec_tick        <= 1'b1;
                    hour_pulse      <= wrap_hour;
                    day_pulse       <= wrap_day;
                end
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Cycle-level scoreboard bench for time_counter (CLK_HZ=4): a seconds-of-day model
// predicts every cycle's outputs, plus directed checks at the interesting boundaries.
module tb_time_counter;

    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       rst, run, load;
    logic [3:0] hr_high_setting, hr_low_setting, min_high_setting, min_low_setting;
    logic [3:0] hr_high_timing, hr_low_timing, min_high_timing, min_low_timing;
    logic [3:0] sec_high_timing, sec_low_timing;
    logic       sec_tick, hour_pulse, day_pulse, load_err;

    int n_vec = 0;
    int n_err = 0;

    int   m_secs = 0;
    int   m_p    = 0;
    logic m_st, m_hp, m_dp, m_err;

    logic [27:0] sb[$];

    time_counter #(.CLK_HZ(HZ)) dut (
        .clk(clk), .rst(rst), .run(run), .load(load),
        .hr_high_setting(hr_high_setting), .hr_low_setting(hr_low_setting),
        .min_high_setting(min_high_setting), .min_low_setting(min_low_setting),
        .hr_high_timing(hr_high_timing), .hr_low_timing(hr_low_timing),
        .min_high_timing(min_high_timing), .min_low_timing(min_low_timing),
        .sec_high_timing(sec_high_timing), .sec_low_timing(sec_low_timing),
        .sec_tick(sec_tick), .hour_pulse(hour_pulse), .day_pulse(day_pulse),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bcd(input int s);
        int h, m, sec;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic logic [27:0] obs();
        return {hr_high_timing, hr_low_timing, min_high_timing, min_low_timing,
                sec_high_timing, sec_low_timing, sec_tick, hour_pulse, day_pulse, load_err};
    endfunction

    // One clock: drive inputs, advance the model, push its prediction, compare after the edge.
    task automatic step(input logic r, input logic ru, input logic ld,
                        input int a, input int b, input int c, input int d);
        int hrs, mins;
        rst = r; run = ru; load = ld;
        hr_high_setting = 4'(a); hr_low_setting = 4'(b);
        min_high_setting = 4'(c); min_low_setting = 4'(d);
        m_st = 0; m_hp = 0; m_dp = 0; m_err = 0;
        hrs  = a * 10 + b;
        mins = c * 10 + d;
        if (r) begin
            m_secs = 0; m_p = 0;
        end else if (ld && a <= 2 && b <= 9 && hrs <= 23 && c <= 5 && d <= 9) begin
            m_secs = (hrs * 60 + mins) * 60; m_p = 0;
        end else begin
            m_err = ld;
            if (ru) begin
                if (m_p == HZ - 1) begin
                    m_p = 0;
                    m_secs = (m_secs + 1) % 86400;
                    m_st = 1;
                    m_hp = (m_secs % 3600) == 0;
                    m_dp = (m_secs == 0);
                end else begin
                    m_p++;
                end
            end
        end
        sb.push_back({bcd(m_secs), m_st, m_hp, m_dp, m_err});
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk("sb_empty", obs(), 28'h0);
        else chk("cycle", obs(), sb.pop_front());
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; run = 0; load = 0;
        hr_high_setting = 0; hr_low_setting = 0; min_high_setting = 0; min_low_setting = 0;
        @(posedge clk); #1;

        // Reset then first second
        step(1, 1, 0, 0, 0, 0, 0);
        chk("reset_state", obs(), 28'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        run_n(3);
        chk("no_tick_yet", {27'h0, sec_tick}, 28'h0);
        run_n(1);
        chk("first_tick", obs(), {24'h000001, 4'b1000});

        // Day rollover
        step(0, 1, 1, 2, 3, 5, 9);
        chk("load_2359", obs(), {24'h235900, 4'b0000});
        run_n(59 * HZ);
        chk("at_235959", obs(), {24'h235959, 4'b1000});
        run_n(HZ);
        chk("day_wrap", obs(), {24'h000000, 4'b1110});
        run_n(1);
        chk("pulses_1cyc", obs(), {24'h000000, 4'b0000});

        // Hour boundary
        step(0, 1, 1, 0, 9, 5, 9);
        run_n(60 * HZ);
        chk("hour_wrap", obs(), {24'h100000, 4'b1100});

        // Invalid loads at 12:34:56
        step(0, 1, 1, 1, 2, 3, 4);
        run_n(56 * HZ);
        chk("at_123456", obs(), {24'h123456, 4'b1000});
        step(0, 0, 1, 2, 4, 0, 0);
        chk("bad_hour", obs(), {24'h123456, 4'b0001});
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err_1cyc", obs(), {24'h123456, 4'b0000});
        step(0, 0, 1, 1, 2, 6, 0);
        chk("bad_min", obs(), {24'h123456, 4'b0001});

        // Hold at prescaler 2
        run_n(2);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("frozen", obs(), {24'h123456, 4'b0000});
        run_n(1);
        chk("resume_1", {27'h0, sec_tick}, 28'h0);
        run_n(1);
        chk("resume_2", obs(), {24'h123457, 4'b1000});

        // Load colliding with a tick
        for (int i = 0; i < HZ && m_p != HZ - 1; i++) run_n(1);
        step(0, 1, 1, 0, 7, 3, 0);
        chk("collide", obs(), {24'h073000, 4'b0000});
        run_n(HZ - 1);
        chk("collide_wait", {27'h0, sec_tick}, 28'h0);
        run_n(1);
        chk("collide_tick", obs(), {24'h073001, 4'b1000});

        // Reset during a load is discarded
        step(1, 1, 1, 1, 1, 1, 1);
        chk("rst_over_load", obs(), 28'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic r, ru, ld;
            int   hi;
            r  = ($urandom_range(0, 79) == 0);
            ru = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 9) == 0);
            hi = ($urandom_range(0, 3) == 0) ? 15 : 9;
            step(r, ru, ld, $urandom_range(0, hi > 9 ? 15 : 2), $urandom_range(0, hi),
                 $urandom_range(0, hi > 9 ? 15 : 5), $urandom_range(0, hi));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
